collision_unit: RTL and testbench

Per-frame collision detector and score keeper for the game pipeline. It consumes the per-pixel layer flags produced by the drawing logic during active video: player, player bullet, enemy, and enemy bullet. It qualifies the overlaps and, at each frame strobe, emits single-cycle hit pulses that feed `player.hit_i`, `player.hit_enemy_i` and `player.add_life_i`. It also maintains a 4-digit BCD score for the HUD.

---
 rtl/collision_unit_pkg.sv | 29 ++
 rtl/collision_unit_bcd_counter.sv | 67 ++++++
 rtl/collision_unit.sv | 128 ++++++++++++
 tb/tb_collision_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/collision_unit_pkg.sv
// Shared types and constants for the collision detector / score keeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package collision_pkg;

    // Player damage state: ARMED can take a hit, COOLDOWN is invulnerable.
    typedef enum logic {
        ARMED    = 1'b0,
        COOLDOWN = 1'b1
    } pstate_t;

    typedef logic [3:0] bcd_digit_t;

    // Highest reachable score; the ones digit never moves, so 9990 is the ceiling.
    localparam logic [15:0] SCORE_MAX = 16'h9990;

    localparam int CNT_W = 8;

    // Saturating increment of an overlap counter by a single-bit hit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] r;
        r = v;
        if (en && (v != {CNT_W{1'b1}})) begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/collision_unit_bcd_counter.sv
// Four-digit BCD score register that advances by ten and saturates at 9990.
// Latency: value updates on the edge that samples inc_i; carry_o is combinational from inc_i.
// Backpressure: none; every increment request is applied or absorbed by saturation.
module bcd_counter
    import collision_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        inc_i,
    output logic [15:0] value_o,
    output logic        carry_o
);

    bcd_digit_t ones_q, tens_q, hund_q, thou_q;
    bcd_digit_t ones_d, tens_d, hund_d, thou_d;
    logic       at_max;
    logic       step;

    assign value_o = {thou_q, hund_q, tens_q, ones_q};
    assign at_max  = (value_o == SCORE_MAX);
    assign step    = inc_i & ~at_max;
    // Thousands digit changes only when both tens and hundreds roll over.
    assign carry_o = step & (tens_q == 4'd9) & (hund_q == 4'd9);

    // Next-state: clear, otherwise ripple a +1 through tens, hundreds, thousands.
    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        hund_d = hund_q;
        thou_d = thou_q;
        if (clear_i) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
            hund_d = 4'd0;
            thou_d = 4'd0;
        end else if (step) begin
            if (tens_q == 4'd9) begin
                tens_d = 4'd0;
                if (hund_q == 4'd9) begin
                    hund_d = 4'd0;
                    thou_d = thou_q + 4'd1;
                end else begin
                    hund_d = hund_q + 4'd1;
                end
            end else begin
                tens_d = tens_q + 4'd1;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ones_q <= 4'd0;
            tens_q <= 4'd0;
            hund_q <= 4'd0;
            thou_q <= 4'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
            hund_q <= hund_d;
            thou_q <= thou_d;
        end
    end

endmodule

// File: rtl/collision_unit.sv
// Per-frame collision qualification, player invulnerability FSM and BCD score.
// Latency: pulses and score update one cycle after the frame_i cycle.
// Backpressure: none; single-cycle pulses, at most one of each per frame.
module collision_unit
    import collision_pkg::*;
#(
    parameter int min_overlap_p     = 4,
    parameter int cooldown_frames_p = 60
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        frame_i,
    input  logic        de_i,
    input  logic        player_area_i,
    input  logic        bullet_area_i,
    input  logic        bullet_flying_i,
    input  logic        enemy_area_i,
    input  logic        enemy_bullet_area_i,
    input  logic        clear_i,
    output logic        hit_enemy_o,
    output logic        player_hit_o,
    output logic        add_life_o,
    output logic        invuln_o,
    output logic [15:0] score_o
);

    localparam logic [CNT_W-1:0] MIN_OVL = CNT_W'(min_overlap_p);
    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(cooldown_frames_p);

    logic             eo, po;
    logic [CNT_W-1:0] e_cnt_q, e_cnt_d, p_cnt_q, p_cnt_d;
    logic [CNT_W-1:0] e_eff, p_eff;
    logic [CNT_W-1:0] cd_cnt_q, cd_cnt_d;
    pstate_t          state_q, state_d;
    logic             frame_eval;
    logic             enemy_hit, player_hit;
    logic             hit_enemy_q, player_hit_q, add_life_q;
    logic             score_carry;

    assign eo = de_i & bullet_flying_i & bullet_area_i & enemy_area_i;
    assign po = de_i & player_area_i & (enemy_area_i | enemy_bullet_area_i);

    // Counts including the current cycle, so an overlap on the strobe itself is seen.
    assign e_eff = sat_inc(e_cnt_q, eo);
    assign p_eff = sat_inc(p_cnt_q, po);

    // A coincident clear swallows the strobe entirely.
    assign frame_eval = frame_i & ~clear_i;
    assign enemy_hit  = frame_eval & (e_eff >= MIN_OVL);

    // Overlap counters: accumulate during the frame, restart after each strobe.
    always_comb begin
        e_cnt_d = e_eff;
        p_cnt_d = p_eff;
        if (clear_i || frame_i) begin
            e_cnt_d = '0;
            p_cnt_d = '0;
        end
    end

    // Player FSM next-state: take a hit when armed, count down strobes when cooling.
    always_comb begin
        state_d    = state_q;
        cd_cnt_d   = cd_cnt_q;
        player_hit = 1'b0;
        if (clear_i) begin
            state_d  = ARMED;
            cd_cnt_d = '0;
        end else if (frame_i) begin
            unique case (state_q)
                ARMED: begin
                    if (p_eff >= MIN_OVL) begin
                        player_hit = 1'b1;
                        cd_cnt_d   = CD_LOAD;
                        state_d    = COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    // The strobe that ends cooldown never evaluates a hit.
                    cd_cnt_d = cd_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cd_cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = ARMED;
                    end
                end
                default: begin
                    state_d  = ARMED;
                    cd_cnt_d = '0;
                end
            endcase
        end
    end

    // State, counters and registered pulses.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            e_cnt_q      <= '0;
            p_cnt_q      <= '0;
            cd_cnt_q     <= '0;
            state_q      <= ARMED;
            hit_enemy_q  <= 1'b0;
            player_hit_q <= 1'b0;
            add_life_q   <= 1'b0;
        end else begin
            e_cnt_q      <= e_cnt_d;
            p_cnt_q      <= p_cnt_d;
            cd_cnt_q     <= cd_cnt_d;
            state_q      <= state_d;
            hit_enemy_q  <= enemy_hit;
            player_hit_q <= player_hit;
            add_life_q   <= enemy_hit & score_carry;
        end
    end

    bcd_counter u_score (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clear_i),
        .inc_i   (enemy_hit),
        .value_o (score_o),
        .carry_o (score_carry)
    );

    assign hit_enemy_o  = hit_enemy_q;
    assign player_hit_o = player_hit_q;
    assign add_life_o   = add_life_q;
    assign invuln_o     = (state_q == COOLDOWN);

endmodule

// File: tb/tb_collision_unit.sv
module tb_collision_unit;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        frame_i = 1'b0;
    logic        de_i = 1'b0;
    logic        player_area_i = 1'b0;
    logic        bullet_area_i = 1'b0;
    logic        bullet_flying_i = 1'b0;
    logic        enemy_area_i = 1'b0;
    logic        enemy_bullet_area_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        hit_enemy_o, player_hit_o, add_life_o, invuln_o;
    logic [15:0] score_o;

    int checks = 0;
    int errors = 0;

    collision_unit #(.min_overlap_p(4), .cooldown_frames_p(60)) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .frame_i             (frame_i),
        .de_i                (de_i),
        .player_area_i       (player_area_i),
        .bullet_area_i       (bullet_area_i),
        .bullet_flying_i     (bullet_flying_i),
        .enemy_area_i        (enemy_area_i),
        .enemy_bullet_area_i (enemy_bullet_area_i),
        .clear_i             (clear_i),
        .hit_enemy_o         (hit_enemy_o),
        .player_hit_o        (player_hit_o),
        .add_life_o          (add_life_o),
        .invuln_o            (invuln_o),
        .score_o             (score_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2ms;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic eo_cycles(input int n);
        if (n > 0) begin
            de_i = 1'b1; bullet_flying_i = 1'b1; bullet_area_i = 1'b1; enemy_area_i = 1'b1;
            repeat (n) cyc();
            de_i = 1'b0; bullet_flying_i = 1'b0; bullet_area_i = 1'b0; enemy_area_i = 1'b0;
        end
    endtask

    task automatic po_cycles(input int n);
        if (n > 0) begin
            de_i = 1'b1; player_area_i = 1'b1; enemy_bullet_area_i = 1'b1;
            repeat (n) cyc();
            de_i = 1'b0; player_area_i = 1'b0; enemy_bullet_area_i = 1'b0;
        end
    endtask

    // Overlaps, then a strobe; returns sampled outputs in the pulse cycle.
    task automatic run_frame(input int n_eo, input int n_po);
        eo_cycles(n_eo);
        po_cycles(n_po);
        frame_i = 1'b1;
        cyc();
        frame_i = 1'b0;
    endtask

    initial begin
        int al_cnt;
        int ph_cnt;

        // Reset state
        repeat (2) cyc();
        chk("rst_hit_enemy", hit_enemy_o, 0);
        chk("rst_player_hit", player_hit_o, 0);
        chk("rst_add_life", add_life_o, 0);
        chk("rst_invuln", invuln_o, 0);
        chk("rst_score", score_o, 16'h0000);
        reset_i = 1'b0;
        cyc();

        // 10 enemy overlaps -> one hit, score 0010, pulse lasts one cycle
        run_frame(10, 0);
        chk("e10_hit", hit_enemy_o, 1);
        chk("e10_score", score_o, 16'h0010);
        chk("e10_no_player_hit", player_hit_o, 0);
        chk("e10_no_add_life", add_life_o, 0);
        cyc();
        chk("e10_pulse_width", hit_enemy_o, 0);

        // Below threshold, twice: counter must restart each frame
        run_frame(3, 0);
        chk("e3_no_hit", hit_enemy_o, 0);
        chk("e3_score", score_o, 16'h0010);
        run_frame(3, 0);
        chk("e3_cleared_no_hit", hit_enemy_o, 0);
        // Exactly at threshold
        run_frame(4, 0);
        chk("e4_hit", hit_enemy_o, 1);
        chk("e4_score", score_o, 16'h0020);

        // Climb to 0990 (97 more hits)
        al_cnt = 0;
        for (int i = 0; i < 97; i++) begin
            run_frame(4, 0);
            if (add_life_o) al_cnt++;
        end
        chk("score_0990", score_o, 16'h0990);
        chk("no_life_below_1000", al_cnt, 0);
        run_frame(4, 0);
        chk("score_1000", score_o, 16'h1000);
        chk("life_at_1000", add_life_o, 1);
        chk("life_with_hit", hit_enemy_o, 1);
        cyc();
        chk("life_pulse_width", add_life_o, 0);

        // 899 hits to 9990: add_life at 2000..9000
        al_cnt = 0;
        for (int i = 0; i < 899; i++) begin
            run_frame(4, 0);
            if (add_life_o) al_cnt++;
        end
        chk("score_9990", score_o, 16'h9990);
        chk("life_count_to_9990", al_cnt, 8);
        run_frame(4, 0);
        chk("sat_hit", hit_enemy_o, 1);
        chk("sat_score", score_o, 16'h9990);
        chk("sat_no_life", add_life_o, 0);

        // Player hit then 60-frame cooldown
        run_frame(0, 20);
        chk("p_hit", player_hit_o, 1);
        chk("p_invuln_rise", invuln_o, 1);
        chk("p_no_enemy_hit", hit_enemy_o, 0);
        cyc();
        chk("p_pulse_width", player_hit_o, 0);
        ph_cnt = 0;
        for (int i = 0; i < 59; i++) begin
            run_frame(0, 20);
            if (player_hit_o) ph_cnt++;
        end
        chk("cd_no_hits", ph_cnt, 0);
        chk("cd_still_invuln", invuln_o, 1);
        run_frame(0, 20);
        chk("cd_end_no_hit", player_hit_o, 0);
        chk("cd_end_invuln_fall", invuln_o, 0);
        run_frame(0, 20);
        chk("rearmed_hit", player_hit_o, 1);
        chk("rearmed_invuln", invuln_o, 1);

        // Clear coincident with strobe, pending e_cnt = 8, while in cooldown
        eo_cycles(8);
        frame_i = 1'b1;
        clear_i = 1'b1;
        cyc();
        frame_i = 1'b0;
        clear_i = 1'b0;
        chk("clr_no_enemy_hit", hit_enemy_o, 0);
        chk("clr_no_player_hit", player_hit_o, 0);
        chk("clr_no_life", add_life_o, 0);
        chk("clr_score", score_o, 16'h0000);
        chk("clr_armed", invuln_o, 0);
        run_frame(0, 5);
        chk("clr_then_player_hit", player_hit_o, 1);

        // Async reset mid-frame with partial counts
        run_frame(4, 0);
        chk("pre_rst_score", score_o, 16'h0010);
        eo_cycles(6);
        reset_i = 1'b1;
        #1;
        chk("mid_rst_score", score_o, 16'h0000);
        chk("mid_rst_invuln", invuln_o, 0);
        chk("mid_rst_hit_enemy", hit_enemy_o, 0);
        cyc();
        reset_i = 1'b0;
        cyc();
        run_frame(0, 0);
        chk("post_rst_no_hit", hit_enemy_o, 0);
        chk("post_rst_no_player_hit", player_hit_o, 0);
        chk("post_rst_score", score_o, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
